fw_ip2_test5: RTL

IP2 test-5 sequencer. On an execute command with test_number==5 it repeatedly loads the ASIC scan chain and shifts out all 768 bits. Each iteration it captures the 3-bit comparator word of one selected pixel into an 8-bin histogram.
Sits between the op-code/execute decoder (upstream: start, cfg_static_1 fields) and the status register and AXI read-back (downstream: done, histogram).

---
 rtl/fw_ip2_test5.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/fw_ip2_test5.sv
// IP2 test-5 sequencer: repeatedly loads and shifts the ASIC scan chain and bins one pixel word per iteration.
// Optional feature macro FW_IP2_T5_SATURATE_EN: histogram bins saturate instead of wrapping.
module fw_ip2_test5 #(
    parameter int SCAN_BITS      = 768,
    parameter int BITS_PER_PIXEL = 3,
    parameter int REPEAT_W       = 10,
    parameter int CNT_W          = 16
) (
    input  logic                      fw_pl_clk1,
    input  logic                      fw_rst_n,
    input  logic                      start,
    input  logic                      status_clear,
    input  logic [7:0]                select_pixel,
    input  logic [REPEAT_W-1:0]       repeat_pixel,
    input  logic [5:0]                test_delay,
    input  logic [5:0]                scan_load_delay,
    input  logic                      scan_load_delay_disable,
    input  logic                      bxclk_rise,
    input  logic                      scan_out_asic,
    output logic                      scan_load,
    output logic                      busy,
    output logic                      done,
    output logic [REPEAT_W:0]         iter_cnt,
    output logic [BITS_PER_PIXEL-1:0] last_value,
    input  logic [BITS_PER_PIXEL-1:0] hist_rd_addr,
    output logic [CNT_W-1:0]          hist_rd_data
);
    localparam int NBINS   = 2 ** BITS_PER_PIXEL;
    localparam int SHIFT_W = $clog2(SCAN_BITS);
    localparam int K_W     = $clog2(BITS_PER_PIXEL);
    localparam logic [REPEAT_W:0]    ONE_IT   = (REPEAT_W+1)'(1);
    localparam logic [CNT_W-1:0]     ONE_CNT  = CNT_W'(1);
    localparam logic [SHIFT_W-1:0]   LAST_IDX = SHIFT_W'(SCAN_BITS - 1);
    localparam logic [K_W-1:0]       LAST_K   = K_W'(BITS_PER_PIXEL - 1);

    typedef enum logic [2:0] {
        ST_IDLE            = 3'd0,
        ST_DELAY_TEST      = 3'd1,
        ST_SCANLOAD_HIGH_1 = 3'd2,
        ST_SCANLOAD_HIGH_2 = 3'd3,
        ST_DELAY_SCANLOAD  = 3'd4,
        ST_SHIFT           = 3'd5,
        ST_ACCUM           = 3'd6,
        ST_DONE            = 3'd7
    } state_e;

    state_e                    state_q;
    logic                      scan_load_q;
    logic                      busy_q;
    logic                      done_q;
    logic [REPEAT_W:0]         iter_cnt_q;
    logic [BITS_PER_PIXEL-1:0] last_value_q;
    logic [CNT_W-1:0]          hist_q [NBINS];
    logic [CNT_W-1:0]          hist_rd_data_q;
    logic [5:0]                dly_cnt_q;
    logic [SHIFT_W-1:0]        shift_idx_q;
    logic [7:0]                pix_q;
    logic [K_W-1:0]            bit_k_q;
    logic [BITS_PER_PIXEL-1:0] word_q;
    logic [7:0]                cfg_sel_q;
    logic [REPEAT_W-1:0]       cfg_repeat_q;
    logic [5:0]                cfg_test_delay_q;
    logic [5:0]                cfg_sld_q;
    logic                      cfg_sld_dis_q;

    logic [CNT_W-1:0]          bin_cur_s;
    logic [CNT_W-1:0]          bin_inc_d;
    logic [REPEAT_W:0]         iter_cnt_d;
    logic [REPEAT_W:0]         iter_target_s;
    logic                      start_ok_s;

    // Bin increment, iteration count and completion target for the ACCUM step
    always_comb begin
        bin_cur_s = hist_q[word_q];
`ifdef FW_IP2_T5_SATURATE_EN
        if (bin_cur_s == {CNT_W{1'b1}}) begin
            bin_inc_d = bin_cur_s;
        end else begin
            bin_inc_d = bin_cur_s + ONE_CNT;
        end
`else
        bin_inc_d = bin_cur_s + ONE_CNT;
`endif
        iter_cnt_d    = iter_cnt_q + ONE_IT;
        iter_target_s = {1'b0, cfg_repeat_q} + ONE_IT;
        start_ok_s    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    // Sequencer FSM with registered outputs; timed steps advance only on bxclk_rise
    always_ff @(posedge fw_pl_clk1) begin
        if (!fw_rst_n) begin
            state_q          <= ST_IDLE;
            scan_load_q      <= 1'b1;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            iter_cnt_q       <= '0;
            last_value_q     <= '0;
            dly_cnt_q        <= 6'd0;
            shift_idx_q      <= '0;
            pix_q            <= 8'd0;
            bit_k_q          <= '0;
            word_q           <= '0;
            cfg_sel_q        <= 8'd0;
            cfg_repeat_q     <= '0;
            cfg_test_delay_q <= 6'd0;
            cfg_sld_q        <= 6'd0;
            cfg_sld_dis_q    <= 1'b0;
            for (int b = 0; b < NBINS; b++) hist_q[b] <= '0;
        end else if (start_ok_s) begin
            // start beats a simultaneous status_clear
            cfg_sel_q        <= select_pixel;
            cfg_repeat_q     <= repeat_pixel;
            cfg_test_delay_q <= test_delay;
            cfg_sld_q        <= scan_load_delay;
            cfg_sld_dis_q    <= scan_load_delay_disable;
            for (int b = 0; b < NBINS; b++) hist_q[b] <= '0;
            iter_cnt_q       <= '0;
            done_q           <= 1'b0;
            busy_q           <= 1'b1;
            scan_load_q      <= 1'b1;
            dly_cnt_q        <= 6'd0;
            state_q          <= ST_DELAY_TEST;
        end else begin
            if (status_clear) begin
                done_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    scan_load_q <= 1'b1;
                end
                ST_DELAY_TEST: begin
                    if (bxclk_rise) begin
                        if (dly_cnt_q + 6'd1 >= cfg_test_delay_q) begin
                            dly_cnt_q <= 6'd0;
                            state_q   <= ST_SCANLOAD_HIGH_1;
                        end else begin
                            dly_cnt_q <= dly_cnt_q + 6'd1;
                        end
                    end
                end
                ST_SCANLOAD_HIGH_1: begin
                    if (bxclk_rise) state_q <= ST_SCANLOAD_HIGH_2;
                end
                ST_SCANLOAD_HIGH_2: begin
                    if (bxclk_rise) begin
                        scan_load_q <= 1'b0;
                        dly_cnt_q   <= 6'd0;
                        shift_idx_q <= '0;
                        pix_q       <= 8'd0;
                        bit_k_q     <= '0;
                        if (cfg_sld_dis_q || (cfg_sld_q == 6'd0)) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q <= ST_DELAY_SCANLOAD;
                        end
                    end
                end
                ST_DELAY_SCANLOAD: begin
                    if (bxclk_rise) begin
                        if (dly_cnt_q + 6'd1 >= cfg_sld_q) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            dly_cnt_q <= dly_cnt_q + 6'd1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bxclk_rise) begin
                        if (pix_q == cfg_sel_q) word_q[bit_k_q] <= scan_out_asic;
                        if (shift_idx_q == LAST_IDX) begin
                            state_q <= ST_ACCUM;
                        end else begin
                            shift_idx_q <= shift_idx_q + SHIFT_W'(1);
                            if (bit_k_q == LAST_K) begin
                                bit_k_q <= '0;
                                pix_q   <= pix_q + 8'd1;
                            end else begin
                                bit_k_q <= bit_k_q + K_W'(1);
                            end
                        end
                    end
                end
                ST_ACCUM: begin
                    last_value_q   <= word_q;
                    hist_q[word_q] <= bin_inc_d;
                    iter_cnt_q     <= iter_cnt_d;
                    scan_load_q    <= 1'b1;
                    if (iter_cnt_d == iter_target_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= ~status_clear;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SCANLOAD_HIGH_1;
                    end
                end
                ST_DONE: begin
                    scan_load_q <= 1'b1;
                    if (status_clear) state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    scan_load_q <= 1'b1;
                end
            endcase
        end
    end

    // Registered histogram read port; during ACCUM it returns the pre-increment value
    always_ff @(posedge fw_pl_clk1) begin
        if (!fw_rst_n) begin
            hist_rd_data_q <= '0;
        end else begin
            hist_rd_data_q <= hist_q[hist_rd_addr];
        end
    end

    assign scan_load    = scan_load_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign iter_cnt     = iter_cnt_q;
    assign last_value   = last_value_q;
    assign hist_rd_data = hist_rd_data_q;
endmodule
